// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32 funct3 encodings; load and store views share the low codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } lsu_state_t;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Encodings with no load/store meaning.
    function automatic logic f3_reserved(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Flags misaligned halfword/word accesses and reserved funct3 encodings.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   funct3_i      access funct3 (size in [1:0], unsigned flag in [2])
//   addr_lo_i     low two bits of the byte address
//   misaligned_o  halfword on odd address, or word not on a 4-byte boundary
//   illegal_o     reserved funct3 (011, 110, 111)
module lsu_align_check
    import lsu_pkg::*;
#(
    parameter int CHECK_ALIGN = 1
) (
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o,
    output logic       illegal_o
);

    always_comb begin
        illegal_o    = f3_reserved(funct3_i);
        misaligned_o = 1'b0;
        if (CHECK_ALIGN != 0) begin
            case (funct3_i[1:0])
                2'b01:   misaligned_o = addr_lo_i[0];
                2'b10:   misaligned_o = |addr_lo_i;
                default: misaligned_o = 1'b0;  // bytes are always aligned
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory bus initiator: one load/store at a time, returns extended load data or store completion.
// Latency: accept->resp_valid is 1 cycle for stores, READ_LATENCY+1 for loads, 0 extra for traps.
// Backpressure: req_ready only in IDLE; response and bus fields held until resp_ready.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake; req_store/req_funct3/req_addr/req_wdata payload
//   resp_valid/resp_ready           response handshake; resp_rdata/resp_error payload
//   dmem_address/funct3/wren/data_in  registered bus outputs to data_mem
//   dmem_data_out                   extended read data from data_mem
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int CHECK_ALIGN  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] dmem_address,
    output logic [2:0]  dmem_funct3,
    output logic        dmem_wren,
    output logic [31:0] dmem_data_in,
    input  logic [31:0] dmem_data_out
);

    localparam int WCW = $clog2(READ_LATENCY + 1);

    lsu_state_t     state_q, state_d;
    lsu_req_t       req_q, req_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           misaligned;
    logic           illegal;

    // Checked against the live request so a trap is decided at acceptance
    // and the bus never sees the access.
    lsu_align_check #(
        .CHECK_ALIGN(CHECK_ALIGN)
    ) u_align_check (
        .funct3_i    (req_funct3),
        .addr_lo_i   (req_addr[1:0]),
        .misaligned_o(misaligned),
        .illegal_o   (illegal)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.store  = req_store;
                    req_d.funct3 = req_funct3;
                    req_d.addr   = req_addr;
                    req_d.wdata  = req_wdata;
                    rdata_d      = '0;  // stores complete with zero data
                    state_d      = (misaligned || illegal) ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                if (req_q.store) begin
                    state_d = RESP;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rdata_d = dmem_data_out;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            RESP, ERR: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP) || (state_q == ERR);
    assign resp_error   = (state_q == ERR);
    assign resp_rdata   = (state_q == RESP) ? rdata_q : 32'd0;

    // Bus fields come straight from the latched request, so they stay
    // stable for the whole transaction including a stalled response.
    assign dmem_address = req_q.addr;
    assign dmem_funct3  = req_q.funct3;
    assign dmem_data_in = req_q.wdata;
    assign dmem_wren    = (state_q == ISSUE) && req_q.store;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a byte-array data memory responder and a reference memory model.
// Latency: responder returns extended read data one cycle after the issue edge.
// Backpressure: bench holds resp_ready low for chosen cycles.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] dmem_address;
    logic [2:0]  dmem_funct3;
    logic        dmem_wren;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out = 32'd0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Memory seen through the bus (written only by DUT stores) and the
    // bench's own expectation of memory contents.
    logic [7:0] bus_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    logic [2:0] store_f3_tbl [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    always #5 clk = ~clk;

    load_store_unit #(
        .READ_LATENCY(1),
        .CHECK_ALIGN (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .dmem_address (dmem_address),
        .dmem_funct3  (dmem_funct3),
        .dmem_wren    (dmem_wren),
        .dmem_data_in (dmem_data_in),
        .dmem_data_out(dmem_data_out)
    );

    // Sign/zero extension of the first 1/2/4 little-endian bytes.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3[1:0])
            2'd0:    return f3[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'd1:    return f3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // data_mem stand-in; the top word (0xFFFFFFFC) plays the LED register.
    always @(posedge clk) begin
        logic [31:0] raw;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = dmem_address + 32'(i);
            raw[8*i +: 8] = bus_mem.exists(a) ? bus_mem[a] : 8'h00;
        end
        dmem_data_out <= extend(dmem_funct3, raw);
        if (dmem_wren === 1'b1) begin
            for (int i = 0; i < (1 << dmem_funct3[1:0]); i++) begin
                a = dmem_address + 32'(i);
                bus_mem[a] = dmem_data_in[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One complete request/response transaction, checked against the model.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        int          size;
        int          lat;
        int          wr;
        int          tmo;
        logic        exp_e;
        logic [31:0] exp_d;
        logic [31:0] raw;
        logic [31:0] ai;

        size  = 1 << f3[1:0];
        exp_e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % size) != 0);
        exp_d = 32'd0;
        if (!st && !exp_e) begin
            for (int i = 0; i < 4; i++) begin
                ai = a + 32'(i);
                raw[8*i +: 8] = ref_mem.exists(ai) ? ref_mem[ai] : 8'h00;
            end
            exp_d = extend(f3, raw);
        end

        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tmo = 0;
        while (req_ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hA5A5A5A5;
        req_addr  = 32'h0000_0FF1;

        lat = 0;
        wr  = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            if (dmem_wren === 1'b1) wr++;
            @(negedge clk);
            lat++;
        end
        chk("resp_valid_rise", {31'd0, resp_valid}, 32'd1);
        if (!exp_e) chk(st ? "store_latency" : "load_latency", 32'(lat), st ? 32'd1 : 32'd2);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (dmem_wren === 1'b1) wr++;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_d);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end

        chk("resp_rdata", resp_rdata, exp_d);
        chk("resp_error", {31'd0, resp_error}, {31'd0, exp_e});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("wren_pulses", 32'(wr), (st && !exp_e) ? 32'd1 : 32'd0);

        if (st && !exp_e) begin
            for (int i = 0; i < size; i++) begin
                ai = a + 32'(i);
                ref_mem[ai] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          hold;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_wren", {31'd0, dmem_wren}, 32'd0);
        chk("rst_address", dmem_address, 32'd0);
        chk("rst_data_in", dmem_data_in, 32'd0);
        reset = 1'b1;

        // Directed sequence.
        do_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0);  // SW
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0);          // LW
        do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 0);          // LB  -> FFFFFFDE
        do_req(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1);          // LBU -> 000000DE
        do_req(1'b0, 3'b001, 32'h0000_0102, 32'd0, 0);          // LH  -> FFFFDEAD
        do_req(1'b0, 3'b101, 32'h0000_0100, 32'd0, 0);          // LHU -> 0000BEEF
        do_req(1'b0, 3'b001, 32'h0000_0101, 32'd0, 0);          // LH misaligned
        do_req(1'b1, 3'b010, 32'h0000_0102, 32'h12345678, 2);   // SW misaligned
        do_req(1'b0, 3'b011, 32'h0000_0100, 32'd0, 0);          // reserved funct3
        do_req(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h80402010, 0);   // SW LED
        do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 0);          // LW LED
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 5);          // stalled response
        do_req(1'b1, 3'b000, 32'h0000_0101, 32'h000000AB, 0);   // SB
        do_req(1'b1, 3'b001, 32'h0000_0102, 32'h0000CAFE, 0);   // SH
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0);          // LW -> CAFEABEF

        // Reset while waiting on read data.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0100;
        chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);                 // accepted, now ISSUE
        req_valid = 1'b0;
        @(negedge clk);                 // now WAIT
        chk("rw_in_wait_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_wren", {31'd0, dmem_wren}, 32'd0);
        reset = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rw_no_late_resp", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;
        do_req(1'b0, 3'b100, 32'h0000_0100, 32'd0, 0);          // LBU after reset

        // Randomized traffic over a small window so loads hit earlier stores.
        for (int k = 0; k < 60; k++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = st ? store_f3_tbl[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a    = 32'h0000_0200 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            do_req(st, f3, a, wd, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
